// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the decode stage and hazard_scoreboard:
// issue info and source operands in, stall and execute-aligned forwarding selects out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int SEL_W      = 2
);
  logic                  issue_valid;
  logic                  issue_we;
  logic                  issue_is_load;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] rs1_decode;
  logic [REG_ADDR_W-1:0] rs2_decode;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  flush;
  logic                  stall;
  logic [SEL_W-1:0]      fwd_sel_a_ex;
  logic [SEL_W-1:0]      fwd_sel_b_ex;
  logic                  issued_ex;

  modport master (
    output issue_valid, issue_we, issue_is_load, issue_rd,
    output rs1_decode, rs2_decode, rs1_used, rs2_used, flush,
    input  stall, fwd_sel_a_ex, fwd_sel_b_ex, issued_ex
  );

  modport slave (
    input  issue_valid, issue_we, issue_is_load, issue_rd,
    input  rs1_decode, rs2_decode, rs1_used, rs2_used, flush,
    output stall, fwd_sel_a_ex, fwd_sel_b_ex, issued_ex
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadow-pipeline hazard detector: decode stall plus registered forwarding selects.
// Optional HAZARD_STATS_EN adds saturating stall_count/fwd_count outputs.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int ALU_AVAIL  = 2,
  parameter int LOAD_AVAIL = 3,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]         stall_count,
  output logic [15:0]         fwd_count
`endif
);

  logic [DEPTH:1]        valid_q;
  logic [DEPTH:1]        load_q;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH:1];

  logic [REG_ADDR_W-1:0] rs   [2];
  logic                  used [2];
  int                    pos  [2];
  logic                  ld   [2];
  logic                  haz  [2];
  logic [SEL_W-1:0]      sel  [2];

  logic                  stall;
  logic                  advance;
  logic [SEL_W-1:0]      sel_a_q;
  logic [SEL_W-1:0]      sel_b_q;
  logic                  issued_q;

  assign rs[0]   = bus.rs1_decode;
  assign rs[1]   = bus.rs2_decode;
  assign used[0] = bus.rs1_used;
  assign used[1] = bus.rs2_used;

  // Scan oldest to youngest so the youngest matching writer is the one left standing.
  always_comb begin
    for (int op = 0; op < 2; op++) begin
      pos[op] = 0;
      ld[op]  = 1'b0;
      haz[op] = 1'b0;
      sel[op] = '0;
      if (used[op] && !(ZERO_REG != 0 && rs[op] == '0)) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (valid_q[k] && rd_q[k] == rs[op]) begin
            pos[op] = k;
            ld[op]  = load_q[k];
          end
        end
      end
      if (pos[op] != 0) begin
        haz[op] = (pos[op] + 1) < (ld[op] ? LOAD_AVAIL : ALU_AVAIL);
        sel[op] = (pos[op] + 1 <= DEPTH) ? SEL_W'(pos[op] + 1) : '0;
      end
    end
  end

  assign stall   = bus.issue_valid & ~bus.flush & (haz[0] | haz[1]);
  assign advance = ~stall & ~bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      load_q   <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      issued_q <= 1'b0;
    end else begin
      valid_q[1] <= bus.issue_valid & bus.issue_we & advance;
      rd_q[1]    <= bus.issue_rd;
      load_q[1]  <= bus.issue_is_load & advance;
      for (int k = 2; k <= DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        load_q[k]  <= load_q[k-1];
      end
      sel_a_q  <= advance ? sel[0] : '0;
      sel_b_q  <= advance ? sel[1] : '0;
      issued_q <= bus.issue_valid & advance;
    end
  end

  assign bus.stall        = stall;
  assign bus.fwd_sel_a_ex = sel_a_q;
  assign bus.fwd_sel_b_ex = sel_b_q;
  assign bus.issued_ex    = issued_q;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if ((sel_a_q != '0 || sel_b_q != '0) && fwd_count != 16'hFFFF)
        fwd_count <= fwd_count + 16'd1;
    end
  end
`endif

endmodule
